store_format_r0: RTL and testbench
==================================

STORE_FORMAT_R0 -- requirements
Module: store_format_r0

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width; the data path is fixed at 32 bits.
REQ-002 SHALL have parameter BIG_ENDIAN, default 1, meaning byte 0 sits on data[31:24] when 1 and on data[7:0] when 0.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  store request present.
REQ-006 in_ready  output  1  request accepted when in_valid and in_ready are both high at a clock edge.
REQ-007 in_addr  input  ADDR_WIDTH  byte address.
REQ-008 in_data  input  32  store value, right-justified.
REQ-009 in_size  input  2  encoding 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 out_valid  output  1  formatted store present.
REQ-011 out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
REQ-012 out_addr  output  ADDR_WIDTH  in_addr with bits [1:0] forced to 00.
REQ-013 out_data  output  32  lane-replicated data.
REQ-014 out_be  output  4  byte enables; bit 3 is data[31:24].
REQ-015 out_err  output  1  misaligned or illegal request.
REQ-016 err_cnt  output  16  error count; present only under REQ-033.

Function
REQ-017 SHALL narrow in_data to the size field: byte uses [7:0] replicated x4, half uses [15:0] replicated x2, word passes through.
REQ-018 SHALL set out_be by lane: byte gives one bit per addr[1:0]; half gives 1100 or 0011 per addr[1]; word gives 1111.
REQ-019 SHALL place byte offset 0 at be[3] when BIG_ENDIAN=1 and at be[0] when BIG_ENDIAN=0; halves SHALL mirror the same way.
REQ-020 SHALL flag an error for half with addr[0]=1, word with addr[1:0]!=00, or size 11; on error out_be=0000, out_err=1, and out_data is passed through unchanged.
REQ-021 SHALL be a registered pipeline with one main register and one skid register; latency from accept to out_valid is exactly 1 cycle.
REQ-022 SHALL drive in_ready = !skid_full, registered only, with no combinational path from out_ready.
REQ-023 SHALL behave as follows when main is empty: accept loads main.
REQ-024 SHALL behave as follows when main is full and out_ready=1: main pops; a simultaneous accept reloads main; an occupied skid moves to main first and a new accept is then impossible.
REQ-025 SHALL behave as follows when main is full, out_ready=0 and an accept occurs: the request loads skid and in_ready falls next cycle.
REQ-026 SHALL preserve request order; no request is dropped or duplicated.
REQ-027 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-028 SHALL sustain one transfer per cycle when out_ready is held at 1.

Reset
REQ-029 On rst=1 at a clock edge, SHALL clear main and skid valid flags, set out_valid=0, set in_ready=1 on the following cycle, and zero out_addr, out_data, out_be and out_err.
REQ-030 Reset mid-operation SHALL discard buffered requests without emitting them.
REQ-031 SHALL ignore in_valid during the reset cycle.
REQ-032 SHALL clear err_cnt to 0 on reset.

Configuration
REQ-033 Macro STORE_FORMAT_ERR_CNT_EN SHALL control error counting.
REQ-034 With STORE_FORMAT_ERR_CNT_EN defined, err_cnt SHALL increment by 1 per accepted erroneous request and saturate at 16'hFFFF.
REQ-035 Without STORE_FORMAT_ERR_CNT_EN, the err_cnt port and its counter SHALL be absent.

Structure
REQ-036 Size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_ILL) SHALL live in the shared MIPS defines/package, shared with the load-side sign_extend path.
REQ-037 Lane and byte-enable generation SHALL be a combinational sub-module, store_lane_gen_r0, instantiated once ahead of the main/skid registers.

Verification
REQ-038 Byte store, addr=0x1003, data=0x000000A5, BIG_ENDIAN=1 -> out_addr=0x1000, out_data=0xA5A5A5A5, out_be=0001, out_err=0, one cycle later.
REQ-039 Half store, addr=0x2002, data=0x1234BEEF -> out_data=0xBEEFBEEF, out_be=0011; same with BIG_ENDIAN=0 -> out_be=1100.
REQ-040 Word store, addr=0x3001 -> out_err=1, out_be=0000; size=11 -> out_err=1; err_cnt increments by 2 with the macro defined.
REQ-041 Three back-to-back requests with out_ready=0 -> in_ready falls after the second; raising out_ready drains the requests in order with no loss.
REQ-042 rst pulsed while both buffers are full -> next cycle out_valid=0, in_ready=1, and no stale output appears afterward.
REQ-043 Random in_valid/out_ready at 50% over 10k requests -> scoreboard matches order and content, with throughput 1/cycle when out_ready=1.

Source files
------------

// File: rtl/store_format_r0_pkg.sv
// ---------------------------------------------------------------------------
// store_format_r0_pkg
// Shared definitions for the store formatting path. The load-side sign_extend
// path uses the same size encodings.
//   DATA_W / BE_W : fixed data path and byte-enable widths
//   size_e        : access size encoding (byte, half, word, illegal)
//   isBadAccess   : misalignment / illegal-size test for a size and offset
//   mirrorBe      : swaps byte-enable lane order between the two endiannesses
// ---------------------------------------------------------------------------
package store_format_r0_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  // A half must sit on an even byte and a word on a word boundary; the
  // reserved encoding is always an error.
  function automatic logic isBadAccess(input size_e size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = |offset;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Lane k of a little-endian view becomes lane 3-k in a big-endian view.
  function automatic logic [BE_W-1:0] mirrorBe(input logic [BE_W-1:0] be);
    return {be[0], be[1], be[2], be[3]};
  endfunction

endpackage

// File: rtl/store_lane_gen_r0.sv
// ---------------------------------------------------------------------------
// store_lane_gen_r0
// Purely combinational lane replication and byte-enable generation for one
// store request.
//   addr_i : byte address            addr_o : word-aligned address
//   data_i : right-justified value   data_o : lane-replicated value
//   size_i : access size encoding    be_o   : byte enables, bit 3 = [31:24]
//                                    err_o  : misaligned or illegal size
// Parameter BIG_ENDIAN selects whether byte offset 0 maps to be[3] (1) or
// be[0] (0).
// ---------------------------------------------------------------------------
module store_lane_gen_r0
  import store_format_r0_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [1:0]            size_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_W-1:0]     data_o,
  output logic [BE_W-1:0]       be_o,
  output logic                  err_o
);

  logic [BE_W-1:0] leBe;
  logic [DATA_W-1:0] narrowData;

  // Enables are first built with byte offset k on bit k, then mirrored for
  // big-endian. Erroneous requests keep their raw data and enable nothing.
  always_comb begin
    leBe       = '0;
    narrowData = data_i;
    case (size_e'(size_i))
      SIZE_BYTE: begin
        narrowData = {4{data_i[7:0]}};
        leBe       = 4'b0001 << addr_i[1:0];
      end
      SIZE_HALF: begin
        narrowData = {2{data_i[15:0]}};
        leBe       = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        leBe = 4'b1111;
      end
      default: begin
        leBe = '0;
      end
    endcase

    addr_o = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    err_o  = isBadAccess(size_e'(size_i), addr_i[1:0]);
    if (err_o) begin
      data_o = data_i;
      be_o   = '0;
    end else begin
      data_o = narrowData;
      be_o   = BIG_ENDIAN ? mirrorBe(leBe) : leBe;
    end
  end

endmodule

// File: rtl/store_format_r0.sv
// ---------------------------------------------------------------------------
// store_format_r0
// Formats store requests into word-aligned, lane-replicated writes with byte
// enables, through a main register backed by one skid register.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake (in_ready = skid empty)
//   in_addr/data/size     : byte address, right-justified data, size code
//   out_valid / out_ready : formatted-store handshake
//   out_addr/data/be/err  : aligned address, replicated data, enables, error
//   err_cnt               : saturating error count, only when the macro
//                           STORE_FORMAT_ERR_CNT_EN is defined
// ---------------------------------------------------------------------------
module store_format_r0
  import store_format_r0_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_size,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_W-1:0]     out_data,
  output logic [BE_W-1:0]       out_be,
  output logic                  out_err
`ifdef STORE_FORMAT_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [BE_W-1:0]       be;
    logic                  err;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fmtAddr;
  logic [DATA_W-1:0]     fmtData;
  logic [BE_W-1:0]       fmtBe;
  logic                  fmtErr;
  entry_t                newEntry;

  logic   mainValid_q, mainValid_d;
  logic   skidValid_q, skidValid_d;
  entry_t mainEntry_q, mainEntry_d;
  entry_t skidEntry_q, skidEntry_d;

  logic accept;
  logic pop;

  store_lane_gen_r0 #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_gen (
    .addr_i(in_addr),
    .data_i(in_data),
    .size_i(in_size),
    .addr_o(fmtAddr),
    .data_o(fmtData),
    .be_o  (fmtBe),
    .err_o (fmtErr)
  );

  assign newEntry = '{addr: fmtAddr, data: fmtData, be: fmtBe, err: fmtErr};

  // in_ready comes straight from the skid flag, so out_ready never reaches it.
  assign in_ready = !skidValid_q;
  assign accept   = in_valid && in_ready;
  assign pop      = mainValid_q && out_ready;

  // Buffer steering. The skid can only be occupied while main is, so an
  // empty main implies an empty skid. When the skid is full in_ready is low,
  // which is why a skid-to-main move never coincides with an accept.
  always_comb begin
    mainValid_d = mainValid_q;
    skidValid_d = skidValid_q;
    mainEntry_d = mainEntry_q;
    skidEntry_d = skidEntry_q;

    if (!mainValid_q) begin
      if (accept) begin
        mainValid_d = 1'b1;
        mainEntry_d = newEntry;
      end
    end else if (pop) begin
      if (skidValid_q) begin
        mainEntry_d = skidEntry_q;
        skidValid_d = 1'b0;
      end else if (accept) begin
        mainEntry_d = newEntry;
      end else begin
        mainValid_d = 1'b0;
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidEntry_d = newEntry;
    end
  end

  // Reset also clears the payload so the outputs read as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      mainEntry_q <= '0;
      skidEntry_q <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
      mainEntry_q <= mainEntry_d;
      skidEntry_q <= skidEntry_d;
    end
  end

  assign out_valid = mainValid_q;
  assign out_addr  = mainEntry_q.addr;
  assign out_data  = mainEntry_q.data;
  assign out_be    = mainEntry_q.be;
  assign out_err   = mainEntry_q.err;

`ifdef STORE_FORMAT_ERR_CNT_EN
  logic [15:0] errCnt_q, errCnt_d;

  // Counts erroneous requests at acceptance and sticks at all-ones.
  always_comb begin
    errCnt_d = errCnt_q;
    if (accept && fmtErr && (errCnt_q != 16'hFFFF)) begin
      errCnt_d = errCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errCnt_q <= '0;
    end else begin
      errCnt_q <= errCnt_d;
    end
  end

  assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_store_format_r0.sv
// ---------------------------------------------------------------------------
// tb_store_format_r0
// Self-checking bench for store_format_r0. Two instances (big- and
// little-endian) share one stimulus stream. A queue-based model predicts
// occupancy, order and content from the store formatting rules; directed
// vectors add literal expectations. Honours STORE_FORMAT_ERR_CNT_EN.
// ---------------------------------------------------------------------------
module tb_store_format_r0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_ready;

  logic        inReadyBe, outValidBe, outErrBe;
  logic [31:0] outAddrBe, outDataBe;
  logic [3:0]  outBeBe;
  logic        inReadyLe, outValidLe, outErrLe;
  logic [31:0] outAddrLe, outDataLe;
  logic [3:0]  outBeLe;
`ifdef STORE_FORMAT_ERR_CNT_EN
  logic [15:0] errCntBe, errCntLe;
  int          modelErrCnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_format_r0 #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b1)) dutBe (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(inReadyBe),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .out_valid(outValidBe), .out_ready(out_ready),
    .out_addr(outAddrBe), .out_data(outDataBe), .out_be(outBeBe), .out_err(outErrBe)
`ifdef STORE_FORMAT_ERR_CNT_EN
    , .err_cnt(errCntBe)
`endif
  );

  store_format_r0 #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b0)) dutLe (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(inReadyLe),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .out_valid(outValidLe), .out_ready(out_ready),
    .out_addr(outAddrLe), .out_data(outDataLe), .out_be(outBeLe), .out_err(outErrLe)
`ifdef STORE_FORMAT_ERR_CNT_EN
    , .err_cnt(errCntLe)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } req_t;

  req_t modelQ[$];
  bit   pendingZero = 1'b0;

  // Expected output for one request, from the formatting rules: the access
  // covers nBytes bytes starting at the offset; each lane repeats the low
  // nBytes of the value; lane k enables be[k] or be[3-k].
  function automatic void expectFor(input req_t r, input bit bigEnd,
                                    output logic [31:0] eAddr, output logic [31:0] eData,
                                    output logic [3:0] eBe, output logic eErr);
    int off;
    int nBytes;
    off    = int'(r.addr[1:0]);
    nBytes = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : (r.size == 2'd2) ? 4 : 0;
    eAddr  = r.addr & 32'hFFFF_FFFC;
    eErr   = (nBytes == 0) || ((off % nBytes) != 0);
    eData  = r.data;
    eBe    = 4'b0000;
    if (!eErr) begin
      for (int i = 0; i < 4; i++) eData[8*i +: 8] = r.data[8*(i % nBytes) +: 8];
      for (int k = 0; k < nBytes; k++) begin
        if (bigEnd) eBe[3 - (off + k)] = 1'b1;
        else        eBe[off + k] = 1'b1;
      end
    end
  endfunction

  logic [31:0] eAddr, eData;
  logic [3:0]  eBe;
  logic        eErr;
  req_t        newReq;
  bit          mAccept, mPop;

  // Compare process: checks the DUTs against the model away from the rising
  // edge, then advances the model to the state after the next rising edge.
  always @(negedge clk) begin
    checkOutput("out_valid_be", 32'(outValidBe), 32'(modelQ.size() > 0));
    checkOutput("out_valid_le", 32'(outValidLe), 32'(modelQ.size() > 0));
    checkOutput("in_ready_be", 32'(inReadyBe), 32'(modelQ.size() < 2));
    checkOutput("in_ready_le", 32'(inReadyLe), 32'(modelQ.size() < 2));
    if (modelQ.size() > 0) begin
      expectFor(modelQ[0], 1'b1, eAddr, eData, eBe, eErr);
      checkOutput("out_addr_be", outAddrBe, eAddr);
      checkOutput("out_data_be", outDataBe, eData);
      checkOutput("out_be_be", 32'(outBeBe), 32'(eBe));
      checkOutput("out_err_be", 32'(outErrBe), 32'(eErr));
      expectFor(modelQ[0], 1'b0, eAddr, eData, eBe, eErr);
      checkOutput("out_addr_le", outAddrLe, eAddr);
      checkOutput("out_data_le", outDataLe, eData);
      checkOutput("out_be_le", 32'(outBeLe), 32'(eBe));
      checkOutput("out_err_le", 32'(outErrLe), 32'(eErr));
    end
    if (pendingZero && !rst) begin
      checkOutput("reset_out_addr", outAddrBe, 32'h0);
      checkOutput("reset_out_data", outDataBe, 32'h0);
      checkOutput("reset_out_be", 32'(outBeBe), 32'h0);
      checkOutput("reset_out_err", 32'(outErrBe), 32'h0);
    end
`ifdef STORE_FORMAT_ERR_CNT_EN
    checkOutput("err_cnt_be", 32'(errCntBe), 32'(modelErrCnt));
    checkOutput("err_cnt_le", 32'(errCntLe), 32'(modelErrCnt));
`endif

    if (rst) begin
      modelQ.delete();
      pendingZero = 1'b1;
`ifdef STORE_FORMAT_ERR_CNT_EN
      modelErrCnt = 0;
`endif
    end else begin
      pendingZero = 1'b0;
      mAccept = in_valid && (modelQ.size() < 2);
      mPop    = (modelQ.size() > 0) && out_ready;
      if (mPop) void'(modelQ.pop_front());
      if (mAccept) begin
        newReq = '{addr: in_addr, data: in_data, size: in_size};
        modelQ.push_back(newReq);
`ifdef STORE_FORMAT_ERR_CNT_EN
        expectFor(newReq, 1'b1, eAddr, eData, eBe, eErr);
        if (eErr && modelErrCnt < 16'hFFFF) modelErrCnt++;
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s,
                               input logic ordy);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    in_size   = s;
    out_ready = ordy;
  endtask

  // One request into an idle pipe; outputs checked against literals while
  // held, then popped.
  task automatic directedOne(input string name, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s, input logic [31:0] xAddr,
                             input logic [31:0] xData, input logic [3:0] xBeBig,
                             input logic [3:0] xBeLittle, input logic xErr);
    applyStimulus(1'b0, 1'b1, a, d, s, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    #2;
    checkOutput({name, "_valid"}, 32'(outValidBe), 32'h1);
    checkOutput({name, "_addr"}, outAddrBe, xAddr);
    checkOutput({name, "_data"}, outDataBe, xData);
    checkOutput({name, "_be_big"}, 32'(outBeBe), 32'(xBeBig));
    checkOutput({name, "_be_little"}, 32'(outBeLe), 32'(xBeLittle));
    checkOutput({name, "_err"}, 32'(outErrBe), 32'(xErr));
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = 32'h0;
    in_data   = 32'h0;
    in_size   = 2'd0;
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h9999, 32'h1, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    #2;
    checkOutput("reset_out_valid", 32'(outValidBe), 32'h0);
    checkOutput("reset_in_ready", 32'(inReadyBe), 32'h1);

    directedOne("byte_1003", 32'h1003, 32'h0000_00A5, 2'd0,
                32'h1000, 32'hA5A5_A5A5, 4'b0001, 4'b1000, 1'b0);
    directedOne("half_2002", 32'h2002, 32'h1234_BEEF, 2'd1,
                32'h2000, 32'hBEEF_BEEF, 4'b0011, 4'b1100, 1'b0);
    directedOne("word_3001", 32'h3001, 32'h1122_3344, 2'd2,
                32'h3000, 32'h1122_3344, 4'b0000, 4'b0000, 1'b1);
    directedOne("size_ill", 32'h4000, 32'hCAFE_F00D, 2'd3,
                32'h4000, 32'hCAFE_F00D, 4'b0000, 4'b0000, 1'b1);
    directedOne("half_odd", 32'h4101, 32'h0000_5566, 2'd1,
                32'h4100, 32'h0000_5566, 4'b0000, 4'b0000, 1'b1);
    directedOne("word_ok", 32'h4204, 32'hDEAD_BEEF, 2'd2,
                32'h4204, 32'hDEAD_BEEF, 4'b1111, 4'b1111, 1'b0);
`ifdef STORE_FORMAT_ERR_CNT_EN
    checkOutput("err_cnt_after_directed", 32'(errCntBe), 32'd3);
`endif

    // Three back-to-back requests against a stalled output.
    applyStimulus(1'b0, 1'b1, 32'h5000, 32'h0000_0011, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h5005, 32'h0000_0022, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h500A, 32'h0000_3333, 2'd1, 1'b0);
    #2;
    checkOutput("stall_in_ready_low", 32'(inReadyBe), 32'h0);
    checkOutput("stall_head_addr", outAddrBe, 32'h5000);
    applyStimulus(1'b0, 1'b1, 32'h500A, 32'h0000_3333, 2'd1, 1'b0);
    #2;
    checkOutput("stall_hold_data", outDataBe, 32'h1111_1111);
    applyStimulus(1'b0, 1'b1, 32'h500A, 32'h0000_3333, 2'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h500A, 32'h0000_3333, 2'd1, 1'b1);
    #2;
    checkOutput("drain_second_addr", outAddrBe, 32'h5004);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    #2;
    checkOutput("drain_third_data", outDataBe, 32'h3333_3333);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);

    // Reset with both buffers full; the buffered requests must vanish.
    applyStimulus(1'b0, 1'b1, 32'h6000, 32'h0000_00AA, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h6001, 32'h0000_00BB, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h6002, 32'h0000_00CC, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    #2;
    checkOutput("rst_full_out_valid", 32'(outValidBe), 32'h0);
    checkOutput("rst_full_in_ready", 32'(inReadyBe), 32'h1);
    checkOutput("rst_full_out_data", outDataBe, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Sustained throughput with out_ready held high.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h7000 + 32'(4 * i), 32'h0100_0000 + 32'(i), 2'd2, 1'b1);
      #2;
      checkOutput("burst_in_ready", 32'(inReadyBe), 32'h1);
      if (i > 0) checkOutput("burst_out_valid", 32'(outValidBe), 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Random handshakes, with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus((i == 700) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                    32'h8000 + 32'($urandom_range(0, 255)), $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    #2;
    checkOutput("final_drained", 32'(outValidBe), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
